// File: rtl/spi_flash_responder_if.sv
// SPI bus between a flash master and the responder: mode 0, active-low select.
interface spi_flash_responder_if;
  logic s_clk;
  logic s_css;
  logic s_mosi;
  logic s_miso;

  modport master (output s_clk, output s_css, output s_mosi, input s_miso);
  modport slave  (input s_clk, input s_css, input s_mosi, output s_miso);
endinterface

// File: rtl/spi_flash_responder.sv
// SPI flash responder: read/program/WREN/WRDI/RDSR over a small byte array,
// with the SPI pins oversampled by the system clock. SYNC_STAGES must be >= 2.
module spi_flash_responder #(
  parameter int MEM_AW      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  p_clk,
  input  logic                  p_reset_n,
  spi_flash_responder_if.slave  spi,
  output logic                  busy,
  output logic                  cmd_err,
  output logic                  wel
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, WR_DATA, STATUS, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] css_sync_q,  css_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   css_prev_q,  css_prev_d;

  state_t               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           tx_q, tx_d;
  logic [MEM_AW-1:0]    addr_q, addr_d;
  logic                 rd_q, rd_d;
  logic                 wel_q, wel_d;
  logic                 wrote_q, wrote_d;
  logic                 miso_q, miso_d;
  logic                 cmd_err_q, cmd_err_d;

  logic [7:0]           mem [2**MEM_AW];
  logic                 mem_we;
  logic [7:0]           byte_in;
  logic [MEM_AW-1:0]    addr_shift, addr_next;
  logic                 sclk_s, css_s, mosi_s;
  logic                 sclk_rise, sclk_fall, css_rise, css_fall;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.s_clk};
    css_sync_d  = {css_sync_q[SYNC_STAGES-2:0],  spi.s_css};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.s_mosi};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    css_s       = css_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    css_prev_d  = css_s;
    sclk_rise   = sclk_s & ~sclk_prev_q;
    sclk_fall   = ~sclk_s & sclk_prev_q;
    css_rise    = css_s & ~css_prev_q;
    css_fall    = ~css_s & css_prev_q;
    byte_in     = {shift_q[6:0], mosi_s};
    // Shifting the 24-bit address through MEM_AW bits keeps only the low bits.
    addr_shift  = {addr_q[MEM_AW-2:0], mosi_s};
    addr_next   = addr_q + MEM_AW'(1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    wel_d     = wel_q;
    wrote_d   = wrote_q;
    miso_d    = miso_q;
    cmd_err_d = 1'b0;
    mem_we    = 1'b0;

    // Deselect wins over any same-cycle clock edge; a partial byte is dropped.
    if (css_rise) begin
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
      wrote_d = 1'b0;
      if (wrote_q) wel_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (css_fall) begin
          state_d = CMD;
          cnt_d   = '0;
          shift_d = '0;
        end
        CMD: if (sclk_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d = '0;
            case (byte_in)
              8'h03:   begin state_d = ADDR; rd_d = 1'b1; end
              8'h02:   begin state_d = ADDR; rd_d = 1'b0; end
              8'h06:   begin state_d = IGNORE; wel_d = 1'b1; end
              8'h04:   begin state_d = IGNORE; wel_d = 1'b0; end
              8'h05:   begin state_d = STATUS; tx_d = {6'b0, wel_q, 1'b0}; end
              default: begin state_d = IGNORE; cmd_err_d = 1'b1; end
            endcase
          end
        end
        ADDR: if (sclk_rise) begin
          addr_d = addr_shift;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            cnt_d   = '0;
            shift_d = '0;
            if (rd_q) begin
              state_d = RD_DATA;
              tx_d    = mem[addr_shift];
            end else begin
              state_d = WR_DATA;
            end
          end
        end
        RD_DATA: if (sclk_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d  = '0;
            addr_d = addr_next;
            tx_d   = mem[addr_next];
          end
        end
        STATUS: if (sclk_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d = '0;
            tx_d  = {6'b0, wel_q, 1'b0};
          end
        end
        WR_DATA: if (sclk_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d   = '0;
            wrote_d = 1'b1;
            addr_d  = addr_next;
            mem_we  = wel_q;
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end

    if (state_d != RD_DATA && state_d != STATUS) miso_d = 1'b0;
  end

  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      sclk_sync_q <= '0;
      css_sync_q  <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      css_prev_q  <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wel_q       <= 1'b0;
      wrote_q     <= 1'b0;
      miso_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      css_sync_q  <= css_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      css_prev_q  <= css_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wel_q       <= wel_d;
      wrote_q     <= wrote_d;
      miso_q      <= miso_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Array has no reset so it maps onto plain RAM.
  always_ff @(posedge p_clk) begin
    if (mem_we) mem[addr_q] <= byte_in;
  end

  assign spi.s_miso = miso_q;
  assign busy       = ~css_s;
  assign cmd_err    = cmd_err_q;
  assign wel        = wel_q;

endmodule
